fredkin_piso_tx: RTL and testbench
==================================

// Module: fredkin_piso_tx
// PURPOSE
//  Parallel-in/serial-out transmitter built from Fredkin-gate reversible logic.
//  Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clk.
//  Framing is given by sout_valid/sout_last.
//  Transmit-side counterpart of the Fredkin D-flip-flop serial capture path; feeds a serial-in receiver.
// PARAMETERS
//  WIDTH      8   bits per word; legal range 2..32
//  MSB_FIRST  1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      synchronous reset, active low
//  load_valid  in   1      load_data is valid this cycle
//  load_ready  out  1      block can accept a word this cycle
//  load_data   in   WIDTH  parallel word to transmit
//  sout        out  1      serial data bit
//  sout_b      out  1      complement of sout at all times, including reset
//  sout_valid  out  1      sout carries a payload bit this cycle
//  sout_last   out  1      sout carries the final bit of the word
// BEHAVIOUR
//  Reset (rst_n==0 at a clk edge):
//   - state=IDLE, shift register=0, bit counter=0.
//   - sout=0, sout_b=1, sout_valid=0, sout_last=0.
//   - load_ready=0 while rst_n==0; load_ready=1 from the first cycle after release.
//  FSM states: IDLE, SHIFT.
//  IDLE:
//   - load_ready=1, sout_valid=0, sout=0.
//   - Accept = load_valid & load_ready at the edge: capture load_data, counter=0, go to SHIFT.
//  SHIFT:
//   - Latency: bit 0 of the frame appears on sout in the first cycle after the accept edge.
//   - One bit per cycle; sout_valid=1 for exactly WIDTH consecutive cycles.
//   - Order: MSB_FIRST=1 sends data[WIDTH-1] first, then down to data[0]; MSB_FIRST=0 reverses this.
//   - sout_last=1 only in the cycle carrying the final bit (counter==WIDTH-1).
//   - load_ready=1 only in the sout_last cycle; 0 in all other SHIFT cycles.
//   - Accept in the sout_last cycle: capture, counter=0, stay in SHIFT (back-to-back, no gap cycle).
//   - No accept in the sout_last cycle: go to IDLE.
//  Ignored input:
//   - load_valid while load_ready==0 has no effect.
//   - The source holds load_valid/load_data until accepted; the block never drops an accepted word.
//  Counter width: $clog2(WIDTH) bits. The counter wraps only through reload; it never counts past WIDTH-1.
//  Reset mid-frame: the frame is aborted at that edge and all outputs take their reset values.
//   A partially sent word is not resumed.
//  Reset together with load_valid: reset wins; the word is not accepted.
//  Implementation:
//   - Load-vs-shift select per register bit is a Fredkin instance (control = load strobe).
//   - Reset gating of each flop D input is a Fredkin AND (C=0, R=A&B with B=rst_n).
//   - sout_b is derived via a Fredkin fan-out/NOT (B=0, C=1).
//   - Garbage outputs are left unconnected.
// TESTING
//  1. Reset: hold rst_n=0 for 3 clk -> sout=0, sout_b=1, sout_valid=0, load_ready=0;
//     release -> load_ready=1 on the next cycle.
//  2. WIDTH=8, MSB_FIRST=1, load 8'hA5 -> starting the cycle after accept, sout=1,0,1,0,0,1,0,1;
//     sout_valid high for 8 cycles; sout_last only on the 8th; then IDLE.
//  3. MSB_FIRST=0, load 8'h01 -> sout=1,0,0,0,0,0,0,0; sout_b is always ~sout.
//  4. Back-to-back: 8'hFF, then 8'h00 presented with load_valid held ->
//     16 consecutive sout_valid cycles (8 ones, then 8 zeros), two sout_last pulses, no gap cycle.
//  5. Reset mid-frame after 3 bits of 8'hC3 -> next cycle sout_valid=0, sout=0;
//     a new load of 8'h81 then sends 1,0,0,0,0,0,0,1 from the start.
//  6. load_valid pulsed in SHIFT cycles 2-6 with 8'h3C -> ignored; the current frame completes unchanged.

Source files
------------

// File: rtl/fredkin_piso_tx.sv
// Parallel-in/serial-out transmitter built from Fredkin-gate reversible logic.
// A word accepted over load_valid/load_ready is shifted out one bit per clk,
// framed by sout_valid/sout_last. A reload in the last-bit cycle gives
// back-to-back frames without a gap cycle.
module fredkin_piso_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             sout_b,
  output logic             sout_valid,
  output logic             sout_last
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Fredkin gate (c, a, b) -> (c, q, r): a and b swap when c is high.
  // Only the output each use needs is modelled; the rest are garbage.
  function automatic logic fk_q(input logic c, input logic a, input logic b);
    return c ? b : a;
  endfunction

  function automatic logic fk_r(input logic c, input logic a, input logic b);
    return c ? a : b;
  endfunction

  state_t           state;
  state_t           state_next;
  state_t           state_d;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    cnt_d;
  logic             accept;
  logic             last;
  logic             head_bit;

  // State, shift register and bit counter; D inputs are already reset-gated.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      shreg <= shreg_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state, handshake, Fredkin load/shift select and reset gating, outputs.
  always_comb begin
    last       = (state == SHIFT) && (cnt == CNT_LAST);
    load_ready = rst_n && ((state == IDLE) || last);
    accept     = load_valid && load_ready;
    state_next = state;
    cnt_next   = cnt;

    if (MSB_FIRST) begin
      head_bit = shreg[WIDTH-1];
      shifted  = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      head_bit = shreg[0];
      shifted  = {1'b0, shreg[WIDTH-1:1]};
    end

    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
          cnt_next   = '0;
        end
      end
      SHIFT: begin
        if (last) begin
          if (accept) cnt_next = '0;
          else        state_next = IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Per bit: Fredkin mux picks load_data on accept, then Fredkin AND with rst_n.
    shreg_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      shreg_d[i] = fk_r(fk_q(accept, shifted[i], load_data[i]), rst_n, 1'b0);
    end
    cnt_d = '0;
    for (int unsigned i = 0; i < CW; i++) begin
      cnt_d[i] = fk_r(cnt_next[i], rst_n, 1'b0);
    end
    state_d = state_t'(fk_r(state_next == SHIFT, rst_n, 1'b0));

    sout       = fk_r(state == SHIFT, head_bit, 1'b0);
    sout_b     = fk_r(sout, 1'b0, 1'b1);
    sout_valid = (state == SHIFT);
    sout_last  = last;
  end

endmodule

// File: tb/tb_fredkin_piso_tx.sv
// Bench for fredkin_piso_tx: an MSB-first and an LSB-first instance share
// the same stimulus; a per-instance queue holds the bits each must send.
module tb_fredkin_piso_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_data;

  logic m_ready, m_sout, m_sout_b, m_valid, m_last;
  logic l_ready, l_sout, l_sout_b, l_valid, l_last;

  bit qm[$];
  bit ql[$];
  int vectors = 0;
  int miscompares = 0;
  bit last_acc;
  int n;
  logic [7:0] w;

  always #5 clk = ~clk;

  fredkin_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(m_ready),
    .load_data(load_data), .sout(m_sout), .sout_b(m_sout_b),
    .sout_valid(m_valid), .sout_last(m_last)
  );

  fredkin_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(l_ready),
    .load_data(load_data), .sout(l_sout), .sout_b(l_sout_b),
    .sout_valid(l_valid), .sout_last(l_last)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_side(input string nm, input int sz, input bit front,
                            input logic rdy, input logic so, input logic sob,
                            input logic vld, input logic lst);
    bit exp_sout;
    exp_sout = (sz > 0) ? front : 1'b0;
    chk({nm, ".sout_valid"}, {7'd0, vld}, {7'd0, sz > 0});
    chk({nm, ".sout"},       {7'd0, so},  {7'd0, exp_sout});
    chk({nm, ".sout_b"},     {7'd0, sob}, {7'd0, !exp_sout});
    chk({nm, ".sout_last"},  {7'd0, lst}, {7'd0, sz == 1});
    chk({nm, ".load_ready"}, {7'd0, rdy}, {7'd0, rst_n && (sz <= 1)});
  endtask

  // Drive one cycle of inputs, update the scoreboard at the edge, check at negedge.
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    bit exp_ready;
    rst_n      = r;
    load_valid = v;
    load_data  = d;
    exp_ready  = r && (qm.size() <= 1);
    @(posedge clk);
    last_acc = r && v && exp_ready;
    if (qm.size() > 0) void'(qm.pop_front());
    if (ql.size() > 0) void'(ql.pop_front());
    if (!r) begin
      qm.delete();
      ql.delete();
    end
    if (last_acc) begin
      for (int i = 0; i < 8; i++) begin
        qm.push_back(d[7-i]);
        ql.push_back(d[i]);
      end
    end
    @(negedge clk);
    check_side("msb", qm.size(), (qm.size() > 0) ? qm[0] : 1'b0,
               m_ready, m_sout, m_sout_b, m_valid, m_last);
    check_side("lsb", ql.size(), (ql.size() > 0) ? ql[0] : 1'b0,
               l_ready, l_sout, l_sout_b, l_valid, l_last);
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;

    // Reset held 3 cycles with load_valid asserted: reset wins.
    repeat (3) step(1'b0, 1'b1, 8'hFF);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);

    // Single frame 8'hA5.
    step(1'b1, 1'b1, 8'hA5);
    repeat (9) step(1'b1, 1'b0, 8'h00);

    // Single frame 8'h01 (LSB instance sends the 1 first).
    step(1'b1, 1'b1, 8'h01);
    repeat (9) step(1'b1, 1'b0, 8'h00);

    // Back-to-back 8'hFF then 8'h00 with load_valid held.
    step(1'b1, 1'b1, 8'hFF);
    n = 0;
    do begin
      step(1'b1, 1'b1, 8'h00);
      n++;
    end while (!last_acc && n < 20);
    chk("b2b_second_accept", {7'd0, last_acc}, 8'd1);
    chk("b2b_accept_cycle", n[7:0], 8'd8);
    repeat (10) step(1'b1, 1'b0, 8'h00);

    // Reset mid-frame after 3 bits of 8'hC3, then a clean 8'h81.
    step(1'b1, 1'b1, 8'hC3);
    repeat (2) step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h81);
    repeat (9) step(1'b1, 1'b0, 8'h00);

    // load_valid pulsed during SHIFT cycles 2-6 is ignored.
    step(1'b1, 1'b1, 8'h5A);
    repeat (5) step(1'b1, 1'b1, 8'h3C);
    repeat (5) step(1'b1, 1'b0, 8'h00);

    // Stream of random words with load_valid held until each is taken.
    for (int k = 0; k < 4; k++) begin
      w = 8'($urandom);
      n = 0;
      do begin
        step(1'b1, 1'b1, w);
        n++;
      end while (!last_acc && n < 20);
      chk("stream_accept", {7'd0, last_acc}, 8'd1);
    end
    repeat (10) step(1'b1, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
